// File: rtl/traffic_pkg.sv
// traffic_pkg: shared definitions for the traffic phase controller.
//   STATE_W - width of the phase-state encoding
//   state_t - controller phase states
package traffic_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_ALL_RED = 3'd0,
    ST_GREEN   = 3'd1,
    ST_YELLOW  = 3'd2,
    ST_WALK    = 3'd3,
    ST_FLASH   = 3'd4
  } state_t;

  // True for the phases in which every approach shows red.
  function automatic logic all_red_phase(state_t s);
    return (s == ST_ALL_RED) || (s == ST_WALK);
  endfunction

endpackage

// File: rtl/phase_timer.sv
// phase_timer: loadable down-counter advanced by a tick strobe.
//   clk, reset - clock and async active-high reset (count <= RST_VAL)
//   tick       - advance strobe; count decrements on ticks until it reaches 0
//   load       - load load_val this edge (wins over the tick decrement)
//   expire     - terminal count: tick present while count is 0
module phase_timer #(
  parameter int            TW      = 8,
  parameter logic [TW-1:0] RST_VAL = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          expire
);

  logic [TW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (tick && (count_q != '0)) begin
      count_d = count_q - TW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= RST_VAL;
    else       count_q <= count_d;
  end

  assign expire = tick && (count_q == '0);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: green/yellow/all-red sequencer over NUM_DIRS approaches
// with a pedestrian walk phase and a flashing-yellow override.
//   clk, reset  - clock and async active-high reset
//   tick        - timing strobe; phase timers only move on tick edges
//   ped_req     - pedestrian request pulse (latched until served)
//   flash_mode  - level, selects flashing yellow on all approaches
//   red/yellow/green - per-direction lamps (bit d = direction d)
//   walk        - pedestrian walk lamp
//   cur_dir     - direction owning the current green/yellow
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_ALL_RED | clearance, all red; then WALK if a request is pending
// ST_GREEN   | cur_dir green, others red
// ST_YELLOW  | cur_dir yellow, others red; exit advances cur_dir
// ST_WALK    | all red, walk lamp lit
// ST_FLASH   | all yellow blinking, no red/green, requests ignored
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int NUM_DIRS      = 2,
  parameter int TW            = 8,
  parameter int GREEN_TICKS   = 5,
  parameter int YELLOW_TICKS  = 2,
  parameter int ALL_RED_TICKS = 1,
  parameter int WALK_TICKS    = 3,
  parameter int FLASH_TICKS   = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        tick,
  input  logic                        ped_req,
  input  logic                        flash_mode,
  output logic [NUM_DIRS-1:0]         red,
  output logic [NUM_DIRS-1:0]         yellow,
  output logic [NUM_DIRS-1:0]         green,
  output logic                        walk,
  output logic [$clog2(NUM_DIRS)-1:0] cur_dir
);

  localparam int DIR_W = $clog2(NUM_DIRS);

  localparam logic [TW-1:0] GREEN_M1   = TW'(GREEN_TICKS - 1);
  localparam logic [TW-1:0] YELLOW_M1  = TW'(YELLOW_TICKS - 1);
  localparam logic [TW-1:0] ALL_RED_M1 = TW'(ALL_RED_TICKS - 1);
  localparam logic [TW-1:0] WALK_M1    = TW'(WALK_TICKS - 1);
  localparam logic [TW-1:0] FLASH_M1   = TW'(FLASH_TICKS - 1);

  localparam logic [NUM_DIRS-1:0] ALL_ONES = {NUM_DIRS{1'b1}};

  state_t              state_q, state_d;
  logic [DIR_W-1:0]    cur_dir_q, cur_dir_d;
  logic                ped_pending_q, ped_pending_d;
  logic                blink_q, blink_d;
  logic [NUM_DIRS-1:0] red_q, red_d;
  logic [NUM_DIRS-1:0] yellow_q, yellow_d;
  logic [NUM_DIRS-1:0] green_q, green_d;
  logic                walk_q, walk_d;

  logic                tmr_load;
  logic [TW-1:0]       tmr_load_val;
  logic                tmr_expire;
  logic [NUM_DIRS-1:0] dir_oh;

  phase_timer #(
    .TW      (TW),
    .RST_VAL (ALL_RED_M1)
  ) u_phase_timer (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .expire   (tmr_expire)
  );

  // Next-state logic. Flash entry/exit does not wait for a tick and
  // overrides any expiry on the same edge.
  always_comb begin
    state_d       = state_q;
    cur_dir_d     = cur_dir_q;
    blink_d       = blink_q;
    ped_pending_d = ped_pending_q | (ped_req && (state_q != ST_FLASH));
    tmr_load      = 1'b0;
    tmr_load_val  = '0;

    if (flash_mode) begin
      ped_pending_d = 1'b0;
      if (state_q != ST_FLASH) begin
        state_d      = ST_FLASH;
        blink_d      = 1'b1;
        tmr_load     = 1'b1;
        tmr_load_val = FLASH_M1;
      end else if (tmr_expire) begin
        blink_d      = ~blink_q;
        tmr_load     = 1'b1;
        tmr_load_val = FLASH_M1;
      end
    end else if (state_q == ST_FLASH) begin
      state_d      = ST_ALL_RED;
      cur_dir_d    = '0;
      blink_d      = 1'b0;
      tmr_load     = 1'b1;
      tmr_load_val = ALL_RED_M1;
    end else if (tmr_expire) begin
      tmr_load = 1'b1;
      case (state_q)
        ST_ALL_RED: begin
          // A request arriving on this very edge is served now.
          if (ped_pending_q || ped_req) begin
            state_d       = ST_WALK;
            tmr_load_val  = WALK_M1;
            ped_pending_d = 1'b0;
          end else begin
            state_d      = ST_GREEN;
            tmr_load_val = GREEN_M1;
          end
        end
        ST_GREEN: begin
          state_d      = ST_YELLOW;
          tmr_load_val = YELLOW_M1;
        end
        ST_YELLOW: begin
          state_d      = ST_ALL_RED;
          tmr_load_val = ALL_RED_M1;
          if (cur_dir_q == DIR_W'(NUM_DIRS - 1)) cur_dir_d = '0;
          else                                   cur_dir_d = cur_dir_q + DIR_W'(1);
        end
        ST_WALK: begin
          state_d      = ST_GREEN;
          tmr_load_val = GREEN_M1;
        end
        default: begin
          state_d      = ST_ALL_RED;
          tmr_load_val = ALL_RED_M1;
        end
      endcase
    end
  end

  // Lamps are decoded from the next state so the registered outputs line
  // up with the state register.
  assign dir_oh = NUM_DIRS'(1) << cur_dir_d;

  always_comb begin
    red_d    = '0;
    yellow_d = '0;
    green_d  = '0;
    walk_d   = 1'b0;
    case (state_d)
      ST_GREEN: begin
        green_d = dir_oh;
        red_d   = ~dir_oh;
      end
      ST_YELLOW: begin
        yellow_d = dir_oh;
        red_d    = ~dir_oh;
      end
      ST_FLASH: yellow_d = {NUM_DIRS{blink_d}};
      default: begin
        red_d  = ALL_ONES;
        walk_d = (state_d == ST_WALK);
      end
    endcase
    if (all_red_phase(state_d)) red_d = ALL_ONES;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_ALL_RED;
      cur_dir_q     <= '0;
      ped_pending_q <= 1'b0;
      blink_q       <= 1'b0;
      red_q         <= ALL_ONES;
      yellow_q      <= '0;
      green_q       <= '0;
      walk_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_dir_q     <= cur_dir_d;
      ped_pending_q <= ped_pending_d;
      blink_q       <= blink_d;
      red_q         <= red_d;
      yellow_q      <= yellow_d;
      green_q       <= green_d;
      walk_q        <= walk_d;
    end
  end

  assign red     = red_q;
  assign yellow  = yellow_q;
  assign green   = green_q;
  assign walk    = walk_q;
  assign cur_dir = cur_dir_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl: a 2-direction and a 3-direction instance
// share one stimulus; a phase/ticks-remaining model checks both every cycle,
// and directed scenarios pin hand-computed lamp values.
module tb_traffic_phase_ctrl;

  localparam int GREEN_T = 5, YELLOW_T = 2, AR_T = 1, WALK_T = 3, FLASH_T = 2;
  localparam int P_AR = 0, P_G = 1, P_Y = 2, P_WK = 3, P_FL = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tick = 1'b1;
  logic ped_req = 1'b0;
  logic flash_mode = 1'b0;

  logic [1:0] red2, yel2, grn2;
  logic       walk2;
  logic       dir2;
  logic [2:0] red3, yel3, grn3;
  logic       walk3;
  logic [1:0] dir3;

  int checks = 0;
  int errors = 0;

  int m_ph[2], m_rem[2], m_dir[2], m_pend[2], m_blink[2];
  int nd[2] = '{2, 3};

  int gexp[9] = '{1, 1, 1, 1, 1, 0, 0, 0, 2};
  int yexp[9] = '{0, 0, 0, 0, 0, 1, 1, 0, 0};

  always #5 clk = ~clk;

  traffic_phase_ctrl dut2 (
    .clk(clk), .reset(reset), .tick(tick), .ped_req(ped_req),
    .flash_mode(flash_mode), .red(red2), .yellow(yel2), .green(grn2),
    .walk(walk2), .cur_dir(dir2)
  );

  traffic_phase_ctrl #(.NUM_DIRS(3)) dut3 (
    .clk(clk), .reset(reset), .tick(tick), .ped_req(ped_req),
    .flash_mode(flash_mode), .red(red3), .yellow(yel3), .green(grn3),
    .walk(walk3), .cur_dir(dir3)
  );

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void model_reset(int i);
    m_ph[i] = P_AR; m_rem[i] = AR_T; m_dir[i] = 0; m_pend[i] = 0; m_blink[i] = 0;
  endfunction

  // m_rem counts ticks still to be spent in the current phase.
  function automatic void model_step(int i, bit ped, bit fm, bit tk);
    bit served = 1'b0;
    if (fm) begin
      m_pend[i] = 0;
      if (m_ph[i] != P_FL) begin
        m_ph[i] = P_FL; m_rem[i] = FLASH_T; m_blink[i] = 1;
      end else if (tk) begin
        m_rem[i]--;
        if (m_rem[i] == 0) begin m_blink[i] = 1 - m_blink[i]; m_rem[i] = FLASH_T; end
      end
      return;
    end
    if (m_ph[i] == P_FL) begin
      m_ph[i] = P_AR; m_rem[i] = AR_T; m_dir[i] = 0;
      return;
    end
    if (tk) begin
      m_rem[i]--;
      if (m_rem[i] == 0) begin
        case (m_ph[i])
          P_AR: if (m_pend[i] != 0 || ped) begin
                  m_ph[i] = P_WK; m_rem[i] = WALK_T; served = 1'b1;
                end else begin
                  m_ph[i] = P_G; m_rem[i] = GREEN_T;
                end
          P_G:  begin m_ph[i] = P_Y; m_rem[i] = YELLOW_T; end
          P_Y:  begin m_ph[i] = P_AR; m_rem[i] = AR_T; m_dir[i] = (m_dir[i] + 1) % nd[i]; end
          default: begin m_ph[i] = P_G; m_rem[i] = GREEN_T; end
        endcase
      end
    end
    if (served) m_pend[i] = 0;
    else if (ped) m_pend[i] = 1;
  endfunction

  function automatic int e_red(int i);
    int mask = (1 << nd[i]) - 1;
    case (m_ph[i])
      P_AR, P_WK: return mask;
      P_G, P_Y:   return mask & ~(1 << m_dir[i]);
      default:    return 0;
    endcase
  endfunction

  function automatic int e_yel(int i);
    if (m_ph[i] == P_Y) return 1 << m_dir[i];
    if (m_ph[i] == P_FL && m_blink[i] != 0) return (1 << nd[i]) - 1;
    return 0;
  endfunction

  function automatic int e_grn(int i);
    return (m_ph[i] == P_G) ? (1 << m_dir[i]) : 0;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) model_reset(i);
      else       model_step(i, ped_req, flash_mode, tick);
    end
    #1;
    chk("m_red2",  red2,  e_red(0));
    chk("m_yel2",  yel2,  e_yel(0));
    chk("m_grn2",  grn2,  e_grn(0));
    chk("m_walk2", walk2, (m_ph[0] == P_WK) ? 1 : 0);
    chk("m_dir2",  dir2,  m_dir[0]);
    chk("m_red3",  red3,  e_red(1));
    chk("m_yel3",  yel3,  e_yel(1));
    chk("m_grn3",  grn3,  e_grn(1));
    chk("m_walk3", walk3, (m_ph[1] == P_WK) ? 1 : 0);
    chk("m_dir3",  dir3,  m_dir[1]);
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1; tick = 1'b1; ped_req = 1'b0; flash_mode = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
    chk("rst_red2", red2, 3);
    chk("rst_grn2", grn2, 0);
    chk("rst_dir2", dir2, 0);
  endtask

  initial begin
    // Default sequence, both widths.
    do_reset();
    for (int k = 1; k <= 25; k++) begin
      cyc();
      if (k <= 9) begin
        chk("seq_grn2", grn2, gexp[k-1]);
        chk("seq_yel2", yel2, yexp[k-1]);
      end
      if (k == 1)  chk("n3_grn_k1", grn3, 1);
      if (k == 9)  chk("n3_grn_k9", grn3, 2);
      if (k == 17) begin chk("n3_grn_k17", grn3, 4); chk("n3_dir_k17", dir3, 2); end
      if (k == 25) begin chk("n3_grn_k25", grn3, 1); chk("n3_dir_k25", dir3, 0); end
    end

    // Pedestrian request during green of direction 0.
    do_reset();
    cyc(); cyc();
    ped_req = 1'b1;
    cyc();
    ped_req = 1'b0;
    for (int k = 4; k <= 12; k++) begin
      cyc();
      if (k == 8) begin chk("ped_ar_red", red2, 3); chk("ped_ar_walk", walk2, 0); end
      if (k >= 9 && k <= 11) begin chk("ped_walk", walk2, 1); chk("ped_walk_red", red2, 3); end
      if (k == 12) begin chk("ped_grn", grn2, 2); chk("ped_grn_walk", walk2, 0); end
    end

    // Flash raised mid-green, with a request ignored during flash.
    do_reset();
    cyc(); cyc(); cyc();
    flash_mode = 1'b1;
    cyc();
    chk("fl_grn", grn2, 0); chk("fl_red", red2, 0); chk("fl_yel_k4", yel2, 3);
    ped_req = 1'b1;
    cyc(); chk("fl_yel_k5", yel2, 3);
    ped_req = 1'b0;
    cyc(); chk("fl_yel_k6", yel2, 0);
    cyc(); chk("fl_yel_k7", yel2, 0);
    cyc(); chk("fl_yel_k8", yel2, 3);
    cyc();
    flash_mode = 1'b0;
    cyc(); chk("fl_exit_red", red2, 3); chk("fl_exit_grn", grn2, 0);
    cyc(); chk("fl_exit_g01", grn2, 1); chk("fl_exit_walk", walk2, 0);

    // Tick held low mid-green.
    do_reset();
    cyc(); cyc(); cyc();
    tick = 1'b0;
    repeat (20) cyc();
    chk("hold_grn", grn2, 1); chk("hold_dir", dir2, 0);
    tick = 1'b1;
    cyc(); chk("hold_t4_grn", grn2, 1);
    cyc(); chk("hold_t5_grn", grn2, 1);
    cyc(); chk("hold_t6_yel", yel2, 1);

    // Request on the all-red expiry edge, then again during walk.
    do_reset();
    for (int k = 1; k <= 8; k++) cyc();
    ped_req = 1'b1;
    cyc(); chk("same_edge_walk", walk2, 1);
    cyc();
    ped_req = 1'b0;
    for (int k = 11; k <= 20; k++) begin
      cyc();
      if (k == 12) begin chk("rewalk_grn", grn2, 2); chk("rewalk_w0", walk2, 0); end
      if (k == 20) chk("rewalk_walk", walk2, 1);
    end

    // Asynchronous reset between edges, during yellow.
    do_reset();
    for (int k = 1; k <= 6; k++) cyc();
    chk("ar_pre_yel", yel2, 1);
    #1;
    reset = 1'b1;
    #1;
    chk("ar_red", red2, 3); chk("ar_yel", yel2, 0);
    chk("ar_grn", grn2, 0); chk("ar_walk", walk2, 0);
    cyc(); cyc();
    reset = 1'b0;

    // Random traffic for the model to check.
    for (int n = 0; n < 400; n++) begin
      tick = ($urandom_range(0, 3) != 0);
      ped_req = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 39) == 0) flash_mode = ~flash_mode;
      cyc();
    end
    flash_mode = 1'b0; ped_req = 1'b0; tick = 1'b1;
    repeat (4) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
